// File: rtl/wb_port_scheduler.sv
// Regfile write-port scheduler: memory path wins, multiply results park in a FIFO.
// Optional statistics counters enabled by defining WB_SCHED_STATS_EN.
module wb_port_scheduler #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dc_regwrite,
    input  logic [ADDR_W-1:0] dc_dst_reg,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic              m5_regwrite,
    input  logic [ADDR_W-1:0] m5_dst_reg,
    input  logic [DATA_W-1:0] m5_result,
    input  logic [ADDR_W-1:0] q1_reg,
    input  logic [ADDR_W-1:0] q2_reg,
    output logic              q1_pend,
    output logic              q2_pend,
    output logic              mul_stall,
    output logic              ovf,
    output logic              wb_regwrite,
    output logic [ADDR_W-1:0] wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_drains
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

    logic [ADDR_W-1:0] dst_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic dc_w, m5_w, fifo_ne, fifo_full;
    logic pop, push_req, push, drop, bypass;

    assign dc_w      = dc_regwrite && (dc_dst_reg != '0);
    assign m5_w      = m5_regwrite && (m5_dst_reg != '0);
    assign fifo_ne   = (count_q != '0);
    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = !dc_w && fifo_ne;
    assign bypass    = !dc_w && !fifo_ne && m5_w;

    // The memory path is younger: a same-cycle multiply to its register is dead.
    assign push_req = m5_w && (dc_w ? (m5_dst_reg != dc_dst_reg) : fifo_ne);
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    always_comb begin
        vld_d = vld_q;
        if (dc_w) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dst_q[i] == dc_dst_reg) vld_d[i] = 1'b0;
            end
        end
        if (pop)  vld_d[head_q] = 1'b0;
        if (push) vld_d[tail_q] = 1'b1;
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d   = ovf_q | drop;
    end

    always_comb begin
        wb_we_d   = 1'b0;
        wb_reg_d  = '0;
        wb_data_d = '0;
        unique case (1'b1)
            dc_w: begin
                wb_we_d   = 1'b1;
                wb_reg_d  = dc_dst_reg;
                wb_data_d = dc_wdata;
            end
            pop: begin
                wb_we_d   = vld_q[head_q];
                wb_reg_d  = vld_q[head_q] ? dst_q[head_q] : '0;
                wb_data_d = vld_q[head_q] ? data_q[head_q] : '0;
            end
            bypass: begin
                wb_we_d   = 1'b1;
                wb_reg_d  = m5_dst_reg;
                wb_data_d = m5_result;
            end
            default: ;
        endcase
    end

    always_comb begin
        q1_pend = 1'b0;
        q2_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && dst_q[i] == q1_reg) q1_pend = 1'b1;
            if (vld_q[i] && dst_q[i] == q2_reg) q2_pend = 1'b1;
        end
        if (q1_reg == '0) q1_pend = 1'b0;
        if (q2_reg == '0) q2_pend = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wb_we_q   <= wb_we_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Payload needs no reset; slot liveness is tracked by vld_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            dst_q[tail_q]  <= m5_dst_reg;
            data_q[tail_q] <= m5_result;
        end
    end

    assign mul_stall   = (count_q >= STALL_CNT);
    assign ovf         = ovf_q;
    assign wb_regwrite = wb_we_q;
    assign wb_wreg     = wb_reg_q;
    assign wb_wdata    = wb_data_q;

`ifdef WB_SCHED_STATS_EN
    logic [15:0] conf_q, conf_d;
    logic [15:0] drn_q, drn_d;

    always_comb begin
        conf_d = conf_q;
        drn_d  = drn_q;
        if (dc_w && m5_w && conf_q != 16'hFFFF) conf_d = conf_q + 16'd1;
        if (pop && drn_q != 16'hFFFF)           drn_d  = drn_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conf_q <= '0;
            drn_q  <= '0;
        end else begin
            conf_q <= conf_d;
            drn_q  <= drn_d;
        end
    end

    assign stat_conflicts = conf_q;
    assign stat_drains    = drn_q;
`else
    assign stat_conflicts = '0;
    assign stat_drains    = '0;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized bench for wb_port_scheduler against a queue-based reference model.
// Directed scenarios first, then random traffic at varying memory-path load.
module tb_wb_port_scheduler;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dc_regwrite = 1'b0;
    logic [AW-1:0] dc_dst_reg = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic          m5_regwrite = 1'b0;
    logic [AW-1:0] m5_dst_reg = '0;
    logic [DW-1:0] m5_result = '0;
    logic [AW-1:0] q1_reg = '0;
    logic [AW-1:0] q2_reg = '0;
    logic          q1_pend, q2_pend, mul_stall, ovf;
    logic          wb_regwrite;
    logic [AW-1:0] wb_wreg;
    logic [DW-1:0] wb_wdata;
    logic [15:0]   stat_conflicts, stat_drains;

    wb_port_scheduler #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .reset(reset),
        .dc_regwrite(dc_regwrite), .dc_dst_reg(dc_dst_reg), .dc_wdata(dc_wdata),
        .m5_regwrite(m5_regwrite), .m5_dst_reg(m5_dst_reg), .m5_result(m5_result),
        .q1_reg(q1_reg), .q2_reg(q2_reg),
        .q1_pend(q1_pend), .q2_pend(q2_pend),
        .mul_stall(mul_stall), .ovf(ovf),
        .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stat_conflicts(stat_conflicts), .stat_drains(stat_drains)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        bit            vld;
    } ent_t;

    ent_t          mq[$];
    bit            m_ovf;
    bit            e_we;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;
    int            m_conf, m_drain;
    int            n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit pend_of(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].vld && mq[i].dst == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; e_we = 0; e_reg = '0; e_data = '0;
        m_conf = 0; m_drain = 0;
    endtask

    task automatic model_push(input logic [AW-1:0] d, input logic [DW-1:0] v);
        ent_t e;
        e.dst = d; e.data = v; e.vld = 1'b1;
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back(e);
    endtask

    task automatic model_step(input bit dcw, input logic [AW-1:0] dcd,
                              input logic [DW-1:0] dcv, input bit mw,
                              input logic [AW-1:0] md, input logic [DW-1:0] mv);
        bit dc_ok, m_ok;
        ent_t h;
        dc_ok = dcw && dcd != 0;
        m_ok  = mw && md != 0;
        e_we = 0; e_reg = '0; e_data = '0;
        if (dc_ok && m_ok) m_conf++;
        if (dc_ok) begin
            e_we = 1; e_reg = dcd; e_data = dcv;
            foreach (mq[i]) if (mq[i].dst == dcd) mq[i].vld = 0;
            if (m_ok && md != dcd) model_push(md, mv);
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_drain++;
            if (h.vld) begin
                e_we = 1; e_reg = h.dst; e_data = h.data;
            end
            if (m_ok) model_push(md, mv);
        end else if (m_ok) begin
            e_we = 1; e_reg = md; e_data = mv;
        end
    endtask

    task automatic cycle(input bit dcw, input logic [AW-1:0] dcd,
                         input logic [DW-1:0] dcv, input bit mw,
                         input logic [AW-1:0] md, input logic [DW-1:0] mv,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        dc_regwrite = dcw; dc_dst_reg = dcd; dc_wdata = dcv;
        m5_regwrite = mw;  m5_dst_reg = md;  m5_result = mv;
        q1_reg = r1; q2_reg = r2;
        #1;
        check("mul_stall", mul_stall, (mq.size() >= DEPTH - MARGIN));
        check("q1_pend", q1_pend, pend_of(r1));
        check("q2_pend", q2_pend, pend_of(r2));
        model_step(dcw, dcd, dcv, mw, md, mv);
        @(posedge clk);
        #1;
        check("wb_regwrite", wb_regwrite, e_we);
        if (e_we) begin
            check("wb_wreg", wb_wreg, e_reg);
            check("wb_wdata", wb_wdata, e_data);
        end
        check("ovf", ovf, m_ovf);
`ifdef WB_SCHED_STATS_EN
        check("stat_conflicts", stat_conflicts, 16'(m_conf));
        check("stat_drains", stat_drains, 16'(m_drain));
`else
        check("stat_conflicts", stat_conflicts, 16'd0);
        check("stat_drains", stat_drains, 16'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        model_reset();
        #2;
        check("rst_we", wb_regwrite, 1'b0);
        check("rst_wreg", wb_wreg, '0);
        check("rst_wdata", wb_wdata, '0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_stall", mul_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // lone multiply bypasses straight to the port
        cycle(0, '0, '0, 1, 5'd3, 32'h12, '0, '0);
        check("lone_wreg", wb_wreg, 5'd3);
        check("lone_wdata", wb_wdata, 32'h12);
        idle(1);

        // conflict: memory first, multiply one cycle later
        cycle(1, 5'd4, 32'hA, 1, 5'd5, 32'hB, '0, '0);
        check("conf_wreg", wb_wreg, 5'd4);
        cycle(0, '0, '0, 0, '0, '0, 5'd5, '0);
        check("drain_wreg", wb_wreg, 5'd5);
        check("drain_wdata", wb_wdata, 32'hB);
        idle(1);

        // squash a parked r6
        cycle(1, 5'd1, 32'h1, 1, 5'd6, 32'h77, 5'd6, '0);
        cycle(1, 5'd6, 32'h55, 0, '0, '0, 5'd6, '0);
        check("sq_data", wb_wdata, 32'h55);
        cycle(0, '0, '0, 0, '0, '0, 5'd6, '0);
        check("sq_pop_we", wb_regwrite, 1'b0);

        // r0 multiply is ignored
        cycle(0, '0, '0, 1, 5'd0, 32'h99, '0, '0);
        check("r0_we", wb_regwrite, 1'b0);

        // pressure: memory path busy, nine multiplies
        for (int i = 0; i < 9; i++)
            cycle(1, 5'd1, 32'(i), 1, 5'(2 + (i % 6)), 32'(100 + i), 5'd2, 5'd3);
        check("press_ovf", ovf, 1'b1);
        check("press_cnt", mq.size(), DEPTH);
        idle(10);

        // reset mid-drain with four entries parked
        for (int i = 0; i < 5; i++)
            cycle(1, 5'd1, 32'(i), 1, 5'(2 + i), 32'(200 + i), '0, '0);
        cycle(0, '0, '0, 0, '0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_we", wb_regwrite, 1'b0);
        check("mrst_stall", mul_stall, 1'b0);
        check("mrst_ovf", ovf, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(6);

        // random traffic, varying memory-path load
        for (int ph = 0; ph < 4; ph++) begin
            int dc_pct;
            dc_pct = (ph == 0) ? 30 : (ph == 1) ? 60 : (ph == 2) ? 90 : 50;
            for (int i = 0; i < 600; i++) begin
                cycle($urandom_range(99) < dc_pct, 5'($urandom_range(7)), $urandom,
                      $urandom_range(99) < 55, 5'($urandom_range(7)), $urandom,
                      5'($urandom_range(7)), 5'($urandom_range(7)));
            end
            idle(DEPTH + 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
